// File: rtl/parity_resp_pkg.sv
// -----------------------------------------------------------------------------
// parity_resp_pkg
// Shared constants and types for the parity tester response decoder:
//   - response byte values (odd marker, three-byte even sequence)
//   - 2-bit error codes reported on the result port
//   - decoder state encoding
// -----------------------------------------------------------------------------
package parity_resp_pkg;

    localparam logic [7:0] RESP_ODD   = 8'hFF;
    localparam logic [7:0] RESP_EVEN0 = 8'hAB;
    localparam logic [7:0] RESP_EVEN1 = 8'h12;
    localparam logic [7:0] RESP_EVEN2 = 8'hDE;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_BAD_BYTE   = 2'd1;
    localparam logic [1:0] ERR_EARLY_LAST = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AB   = 2'd1,
        S_12   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active-high
//   inc    in   increment request
//   count  out  current count (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/parity_resp_decoder.sv
// -----------------------------------------------------------------------------
// parity_resp_decoder
// Consumes the parity tester's AXI-Stream response channel, decodes each
// response (0xFF = odd; 0xAB,0x12,0xDE = even), and emits one classified
// result per response through a one-entry valid/ready result slot. Malformed
// sequences and mid-sequence upstream stalls are reported as errors.
//
// Build option: define PARITY_RESP_COUNTERS_EN to implement the saturating
// odd/even/error statistics counters; otherwise the counter ports read 0.
//
// Ports:
//   a_clk          in   clock, rising edge
//   axis_aresetn   in   synchronous reset, ACTIVE-HIGH despite the name
//   axis_s_tvalid  in   response beat valid
//   axis_s_tdata   in   response byte
//   axis_s_tready  out  decoder ready (= !res_valid || res_ready)
//   axis_s_tlast   in   response end marker, sampled on accepted beats
//   res_valid      out  result available
//   res_ready      in   result consumer ready
//   res_odd        out  1 = odd, 0 = even (valid when res_err_code = 0)
//   res_err_code   out  0 none, 1 bad byte, 2 early last, 3 timeout
//   cnt_odd        out  odd results seen (saturating)
//   cnt_even       out  even results seen (saturating)
//   cnt_err        out  error results seen (saturating)
// -----------------------------------------------------------------------------
module parity_resp_decoder
    import parity_resp_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             a_clk,
    input  logic             axis_aresetn,
    input  logic             axis_s_tvalid,
    input  logic [7:0]       axis_s_tdata,
    output logic             axis_s_tready,
    input  logic             axis_s_tlast,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_odd,
    output logic [1:0]       res_err_code,
    output logic [CNT_W-1:0] cnt_odd,
    output logic [CNT_W-1:0] cnt_even,
    output logic [CNT_W-1:0] cnt_err
);

    state_t      r_state;
    logic [15:0] r_to_cnt;
    logic        r_res_valid;
    logic        r_res_odd;
    logic [1:0]  r_res_err;

    logic        w_tready;
    logic        w_accept;
    logic        w_idle_cyc;
    logic        w_timeout;
    state_t      w_next_state;
    logic        w_gen;
    logic        w_gen_odd;
    logic [1:0]  w_gen_err;

    // The slot can take a new result whenever it is empty or draining now.
    assign w_tready   = !r_res_valid || res_ready;
    assign w_accept   = axis_s_tvalid && w_tready;
    // Upstream idle: we could accept but nothing is offered. Backpressure
    // cycles (w_tready = 0) are deliberately excluded.
    assign w_idle_cyc = w_tready && !axis_s_tvalid;
    // Fires on the TIMEOUT_CYC-th idle cycle; an accepted beat can never
    // coincide because w_idle_cyc requires tvalid = 0.
    assign w_timeout  = (r_state != S_IDLE) && w_idle_cyc &&
                        (r_to_cnt == 16'(TIMEOUT_CYC - 1));

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_gen        = 1'b0;
        w_gen_odd    = 1'b0;
        w_gen_err    = ERR_NONE;
        if (w_accept) begin
            unique case (r_state)
                S_IDLE: begin
                    if (axis_s_tdata == RESP_ODD) begin
                        w_gen     = 1'b1;
                        w_gen_odd = 1'b1;
                    end else if (axis_s_tdata == RESP_EVEN0) begin
                        if (axis_s_tlast) begin
                            w_gen     = 1'b1;
                            w_gen_err = ERR_EARLY_LAST;
                        end else begin
                            w_next_state = S_AB;
                        end
                    end else begin
                        w_gen     = 1'b1;
                        w_gen_err = ERR_BAD_BYTE;
                    end
                end
                S_AB: begin
                    w_next_state = S_IDLE;
                    if (axis_s_tdata == RESP_EVEN1) begin
                        if (axis_s_tlast) begin
                            w_gen     = 1'b1;
                            w_gen_err = ERR_EARLY_LAST;
                        end else begin
                            w_next_state = S_12;
                        end
                    end else begin
                        // Offending byte is consumed, not re-decoded from idle.
                        w_gen     = 1'b1;
                        w_gen_err = ERR_BAD_BYTE;
                    end
                end
                S_12: begin
                    w_next_state = S_IDLE;
                    w_gen        = 1'b1;
                    if (axis_s_tdata != RESP_EVEN2) begin
                        w_gen_err = ERR_BAD_BYTE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end else if (w_timeout) begin
            w_next_state = S_IDLE;
            w_gen        = 1'b1;
            w_gen_err    = ERR_TIMEOUT;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge a_clk) begin
        if (axis_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge a_clk) begin
        if (axis_aresetn) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_IDLE) || (w_next_state == S_IDLE) || w_accept) begin
            r_to_cnt <= '0;
        end else if (w_idle_cyc) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    // One-entry result slot; a new result takes priority over draining so a
    // simultaneous drain-and-load keeps res_valid high.
    always_ff @(posedge a_clk) begin
        if (axis_aresetn) begin
            r_res_valid <= 1'b0;
            r_res_odd   <= 1'b0;
            r_res_err   <= ERR_NONE;
        end else if (w_gen) begin
            r_res_valid <= 1'b1;
            r_res_odd   <= w_gen_odd;
            r_res_err   <= w_gen_err;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign axis_s_tready = w_tready;
    assign res_valid     = r_res_valid;
    assign res_odd       = r_res_odd;
    assign res_err_code  = r_res_err;

`ifdef PARITY_RESP_COUNTERS_EN
    logic w_inc_odd;
    logic w_inc_even;
    logic w_inc_err;

    assign w_inc_odd  = w_gen && (w_gen_err == ERR_NONE) &&  w_gen_odd;
    assign w_inc_even = w_gen && (w_gen_err == ERR_NONE) && !w_gen_odd;
    assign w_inc_err  = w_gen && (w_gen_err != ERR_NONE);

    sat_counter #(.W(CNT_W)) u_cnt_odd (
        .clk   (a_clk),
        .rst   (axis_aresetn),
        .inc   (w_inc_odd),
        .count (cnt_odd)
    );

    sat_counter #(.W(CNT_W)) u_cnt_even (
        .clk   (a_clk),
        .rst   (axis_aresetn),
        .inc   (w_inc_even),
        .count (cnt_even)
    );

    sat_counter #(.W(CNT_W)) u_cnt_err (
        .clk   (a_clk),
        .rst   (axis_aresetn),
        .inc   (w_inc_err),
        .count (cnt_err)
    );
`else
    assign cnt_odd  = '0;
    assign cnt_even = '0;
    assign cnt_err  = '0;
`endif

endmodule

// File: doc/parity_resp_decoder.md
Name: parity_resp_decoder

Overview:
- Downstream consumer of the parity tester's AXI-Stream response channel.
- Decodes response byte sequences:
  - 0xFF means odd parity.
  - 0xAB, 0x12, 0xDE means even parity.
- Emits one classified result per response through a valid/ready result port.
- Flags malformed or stalled sequences and keeps saturating statistics counters for system-level checking.

Parameters:
- CNT_W, 16, width of each statistics counter.
- TIMEOUT_CYC, 64, upstream-idle cycles tolerated mid-sequence before abort; legal range 1..65535.

Ports:
- a_clk  in  1  system clock; all logic on rising edge.
- axis_aresetn  in  1  synchronous reset, active-high (asserted = 1) despite the name.
- axis_s_tvalid  in  1  response beat valid.
- axis_s_tdata  in  8  response byte.
- axis_s_tready  out  1  decoder ready.
- axis_s_tlast  in  1  response end marker.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_odd  out  1  1 = odd parity reported, 0 = even; meaningful only when res_err_code = 0.
- res_err_code  out  2  0 none, 1 bad byte, 2 early last, 3 timeout.
- cnt_odd  out  CNT_W  odd results seen.
- cnt_even  out  CNT_W  even results seen.
- cnt_err  out  CNT_W  error results seen.

Behaviour:
- Reset values:
  - State = S_IDLE.
  - res_valid, res_odd, res_err_code, all counters and the timeout counter = 0.
  - axis_s_tready = 1 (it is combinational; see next item).
  - Reset mid-sequence discards partial progress and any held result.
- Ready and acceptance:
  - axis_s_tready = !res_valid || res_ready, combinational.
  - A beat is accepted when axis_s_tvalid && axis_s_tready.
  - axis_s_tlast is sampled only on accepted beats.
- Result slot:
  - One-entry result register.
  - A result generated by an accepted beat (or by a timeout) sets res_valid on the next edge.
  - res_valid holds, with stable fields, until res_valid && res_ready.
  - Simultaneous drain and new result: the new result loads and res_valid stays 1.
- Latency: one cycle from the completing beat to res_valid.
- State machine, on each accepted beat:
  - S_IDLE:
    - 0xFF: odd result, stay in S_IDLE.
    - 0xAB with tlast=0: go to S_AB.
    - 0xAB with tlast=1: error 2, stay in S_IDLE.
    - Any other byte: error 1, stay in S_IDLE.
  - S_AB:
    - 0x12 with tlast=0: go to S_12.
    - 0x12 with tlast=1: error 2, go to S_IDLE.
    - Any other byte: error 1, go to S_IDLE; the offending byte is dropped, not re-decoded.
  - S_12:
    - 0xDE: even result, go to S_IDLE.
    - Any other byte: error 1, go to S_IDLE; the offending byte is dropped.
  - tlast on a completing byte (0xFF, 0xDE) is ignored, 0 or 1.
- Timeout (S_AB and S_12 only):
  - Counts cycles with axis_s_tready=1 and axis_s_tvalid=0.
  - Clears on any accepted beat or on entering S_IDLE.
  - Backpressure cycles (tready=0) neither count nor clear.
  - On reaching TIMEOUT_CYC: error 3 result, go to S_IDLE.
  - A beat accepted in the same cycle wins and the timeout does not fire.
- Counters:
  - Exactly one counter increments per generated result, chosen by type.
  - Counters saturate at 2^CNT_W-1 and never wrap.

Optional Feature:
- PARITY_RESP_COUNTERS_EN defined: cnt_odd, cnt_even and cnt_err are implemented as above.
- Not defined: no counter flops; the three counter ports are tied to 0. Decoding, result port and timeout are unchanged.

Decomposition:
- Package parity_resp_pkg holds:
  - Response byte constants RESP_ODD=8'hFF, RESP_EVEN0=8'hAB, RESP_EVEN1=8'h12, RESP_EVEN2=8'hDE.
  - Error code constants ERR_NONE, ERR_BAD_BYTE, ERR_EARLY_LAST, ERR_TIMEOUT.
  - State enum S_IDLE, S_AB, S_12.
- One sub-module, sat_counter (parameter W; inputs clk, sync reset, inc; output count), instantiated three times.

Test Plan:
- Beat 0xFF, tlast=1, res_ready=1 -> next cycle res_valid=1, res_odd=1, err=0; cnt_odd=1.
- Beats 0xAB, 0x12, 0xDE back-to-back, tlast on 0xDE -> single result with res_odd=0, err=0; cnt_even=1; no result after 0xAB or 0x12.
- Beats 0xAB, 0x55 -> err=1 after 0x55, state back to S_IDLE; then 0xFF -> odd result; cnt_err=1, cnt_odd=1.
- Beat 0xAB with tlast=1 -> err=2; following 0x12 -> err=1.
- 0xAB, then tvalid low for 64 cycles (TIMEOUT_CYC=64) -> err=3 on the 64th idle cycle's following edge. Repeat with a beat on cycle 64 -> no timeout.
- res_ready=0 after an odd result -> tready=0; the held result stays stable for 10 cycles and the timeout does not advance. Then res_ready=1 with a simultaneous 0xFF beat -> second odd result loads, res_valid stays 1.
